// File: rtl/rmii_rx_frame_filter.sv
// Receive-side Ethernet frame filter: destination MAC match, length and FCS check, 6-byte header delay line.
// Optional: define RMII_RX_BRDCST_EN to also accept the broadcast destination ff:ff:ff:ff:ff:ff.
module rmii_rx_frame_filter #(
  parameter logic [47:0] P_MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter int          P_MIN_LEN  = 64,
  parameter int          P_MAX_LEN  = 1522
) (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic [8:0]  rx_byte,
  input  logic        rx_byte_vld,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_err,
  output logic [15:0] frm_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] crc_err_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_PASS    = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DISCARD = 3'd4;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [11:0] MIN_LEN     = 12'(P_MIN_LEN);
  localparam logic [11:0] MAX_LEN     = 12'(P_MAX_LEN);

  logic [2:0]  state;
  logic        prev_flag;
  logic        armed;      // a low in-frame flag has been seen since reset
  logic        ipg_seen;   // a new frame started while the previous one drains
  logic [31:0] crc;
  logic [11:0] len;
  logic [47:0] dl;         // delay line, oldest byte in [47:40]
  logic [2:0]  drain_cnt;

  logic        flag, take, sof, eof;
  logic [31:0] crc_upd;
  logic [11:0] len_upd;
  logic [47:0] dl_upd;
  logic        addr_ok;
  logic        frame_err;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    flag    = rx_byte[8];
    take    = rx_byte_vld & flag;
    sof     = flag & ~prev_flag;
    eof     = prev_flag & ~flag;
    crc_upd = crc32_byte((state == S_IDLE) ? CRC_INIT : crc, rx_byte[7:0]);
    len_upd = (state == S_IDLE) ? 12'd1 : ((len == 12'hFFF) ? len : len + 12'd1);
    dl_upd  = {dl[39:0], rx_byte[7:0]};
    addr_ok = (dl_upd == P_MAC_ADDR);
`ifdef RMII_RX_BRDCST_EN
    addr_ok = addr_ok | (dl_upd == 48'hFFFF_FFFF_FFFF);
`endif
    frame_err = (crc != CRC_RESIDUE) | (len < MIN_LEN) | (len > MAX_LEN);
  end

  // NOTE: sequential state uses non-blocking assignments only; the delay line is
  // reset too because its contents are observable on m_data during the drain.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state       <= S_IDLE;
      prev_flag   <= 1'b0;
      armed       <= 1'b0;
      ipg_seen    <= 1'b0;
      crc         <= CRC_INIT;
      len         <= 12'd0;
      dl          <= 48'd0;
      drain_cnt   <= 3'd0;
      m_data      <= 8'd0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_err       <= 1'b0;
      frm_cnt     <= 16'd0;
      drop_cnt    <= 16'd0;
      crc_err_cnt <= 16'd0;
    end else begin
      prev_flag <= flag;
      if (!flag) armed <= 1'b1;
      m_data  <= 8'd0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_err   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (take && armed) begin
            crc   <= crc_upd;
            len   <= len_upd;
            dl    <= dl_upd;
            state <= S_HDR;
          end
        end

        S_HDR: begin
          if (eof) begin
            drop_cnt <= drop_cnt + 16'd1;
            state    <= S_IDLE;
          end else if (take) begin
            crc <= crc_upd;
            len <= len_upd;
            dl  <= dl_upd;
            if (len == 12'd5) state <= addr_ok ? S_PASS : S_DISCARD;
          end
        end

        S_PASS: begin
          if (eof) begin
            // a frame that ended right after its destination address has no payload to forward
            if (len == 12'd6) begin
              drop_cnt <= drop_cnt + 16'd1;
              state    <= S_IDLE;
            end else begin
              drain_cnt <= 3'd0;
              ipg_seen  <= 1'b0;
              state     <= S_DRAIN;
            end
          end else if (take) begin
            crc     <= crc_upd;
            len     <= len_upd;
            dl      <= dl_upd;
            m_valid <= 1'b1;
            m_data  <= dl[47:40];
          end
        end

        S_DRAIN: begin
          m_valid   <= 1'b1;
          m_data    <= dl[47:40];
          dl        <= {dl[39:0], 8'h00};
          drain_cnt <= drain_cnt + 3'd1;
          if (sof) ipg_seen <= 1'b1;
          if (eof && ipg_seen) begin
            drop_cnt <= drop_cnt + 16'd1;
            ipg_seen <= 1'b0;
          end
          if (drain_cnt == 3'd5) begin
            m_last  <= 1'b1;
            m_err   <= frame_err;
            frm_cnt <= frm_cnt + 16'd1;
            if (crc != CRC_RESIDUE) crc_err_cnt <= crc_err_cnt + 16'd1;
            ipg_seen <= 1'b0;
            // a frame that overlapped the drain is swallowed whole by DISCARD
            state <= (sof || (ipg_seen && !eof)) ? S_DISCARD : S_IDLE;
          end
        end

        S_DISCARD: begin
          if (eof) begin
            drop_cnt <= drop_cnt + 16'd1;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
